// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared definitions for the RV32I decode/issue stage:
//                major opcode constants, the canonical NOP encoding, the
//                decode FSM state type and opcode usage-class helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HAZ   = 2'd2
  } dec_state_e;

  function automatic logic op_reads_rs1(input logic [6:0] op);
    logic r;
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH: r = 1'b1;
      default:                                             r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_reads_rs2(input logic [6:0] op);
    logic r;
    case (op)
      OP_R, OP_STORE, OP_BRANCH: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_writes_rd(input logic [6:0] op);
    logic r;
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: r = 1'b1;
      default:                                                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_issue_ctrl_if
//  Description : Bundle of the fetch, decoder, execute and writeback signals
//                seen by the decode/issue controller.
//                slave  : the controller side
//                master : the surrounding pipeline (fetch/decoder/execute)
//  Ports       : if_valid/if_ready/if_inst/if_pc   fetch handshake
//                dec_inst/dec_pc                   decode register contents
//                id_opcode/id_rs1/id_rs2/id_rd     decoder fields of dec_inst
//                ex_valid/ex_ready                 issue handshake
//                wb_valid/wb_rd                    register release
//                flush, sb_err                     flush request, sticky error
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_issue_ctrl_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] dec_inst;
  logic [XLEN-1:0] dec_pc;
  logic [6:0]      id_opcode;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            ex_valid;
  logic            ex_ready;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            flush;
  logic            sb_err;

  modport slave (
    input  if_valid, if_inst, if_pc, id_opcode, id_rs1, id_rs2, id_rd,
           ex_ready, wb_valid, wb_rd, flush,
    output if_ready, dec_inst, dec_pc, ex_valid, sb_err
  );

  modport master (
    output if_valid, if_inst, if_pc, id_opcode, id_rs1, id_rs2, id_rd,
           ex_ready, wb_valid, wb_rd, flush,
    input  if_ready, dec_inst, dec_pc, ex_valid, sb_err
  );
endinterface
`default_nettype wire

// File: rtl/decode_issue_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : 32 per-register outstanding-write counters. Counts up on
//                issue of a write, down on release. Lookups report the count
//                as it will be after this cycle's release, so a retiring
//                write unblocks its consumer in the same cycle.
//  Ports       : clk, rst_n          clock, async active-low reset
//                i_iss_en/i_iss_rd   issue of a write to i_iss_rd
//                i_rel_en/i_rel_rd   release of i_rel_rd
//                i_rs1/i_rs2         read-port lookups -> o_busy_rs1/o_busy_rs2
//                i_rd                destination lookup -> o_sat_rd
//                o_sb_err            sticky: release of a zero counter
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
  parameter int PEND_W = 2
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       i_iss_en,
  input  wire logic [4:0] i_iss_rd,
  input  wire logic       i_rel_en,
  input  wire logic [4:0] i_rel_rd,
  input  wire logic [4:0] i_rs1,
  input  wire logic [4:0] i_rs2,
  input  wire logic [4:0] i_rd,
  output logic            o_busy_rs1,
  output logic            o_busy_rs2,
  output logic            o_sat_rd,
  output logic            o_sb_err
);

  localparam logic [PEND_W-1:0] C_MAX = '1;

  logic [32*PEND_W-1:0] w_cnt_flat;
  logic [31:0]          w_inc;
  logic [31:0]          w_dec;
  logic [31:0]          w_uflow;
  logic                 r_err;

  // x0 is never tracked: its select bits stay clear.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (i_iss_en && (i_iss_rd != 5'd0)) w_inc[i_iss_rd] = 1'b1;
    if (i_rel_en && (i_rel_rd != 5'd0)) w_dec[i_rel_rd] = 1'b1;
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_cnt
    logic [PEND_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_inc[gi] && !w_dec[gi]) begin
        if (r_cnt != C_MAX) r_cnt <= r_cnt + 1'b1;
      end else if (w_dec[gi] && !w_inc[gi]) begin
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_cnt_flat[gi*PEND_W +: PEND_W] = r_cnt;
    assign w_uflow[gi] = w_dec[gi] && !w_inc[gi] && (r_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else if (|w_uflow) r_err <= 1'b1;
  end

  // Count of idx after this cycle's release (never below zero).
  function automatic logic [PEND_W-1:0] post_rel(input logic [4:0] idx);
    logic [PEND_W-1:0] c;
    logic              rel;
    c   = w_cnt_flat[32'(idx)*PEND_W +: PEND_W];
    rel = i_rel_en && (i_rel_rd == idx) && (idx != 5'd0) && (c != '0);
    return c - PEND_W'(rel);
  endfunction

  assign o_busy_rs1 = (i_rs1 != 5'd0) && (post_rel(i_rs1) != '0);
  assign o_busy_rs2 = (i_rs2 != 5'd0) && (post_rel(i_rs2) != '0);
  assign o_sat_rd   = (i_rd  != 5'd0) && (post_rel(i_rd) == C_MAX);
  assign o_sb_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : decode_issue_ctrl
//  Description : Decode-stage sequencer for the RV32I core. Holds one fetched
//                instruction, stalls it on RAW hazards or scoreboard
//                saturation, and issues it to execute with valid/ready.
//  Ports       : clk, rst_n   clock, async active-low reset
//                bus          decode_issue_ctrl_if.slave (fetch, decoder,
//                             execute, writeback, flush, sb_err)
//                stall_cycles, flush_cnt  (DECODE_PERF_CNT_EN only)
//  Config      : `define DECODE_PERF_CNT_EN adds saturating 16-bit counters of
//                scoreboard-blocked cycles and flushes of a valid instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_ctrl
  import core_pkg::*;
#(
  parameter int PEND_W = 2,
  parameter int XLEN   = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  decode_issue_ctrl_if.slave bus
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cycles,
  output logic [15:0]        flush_cnt
`endif
);

  dec_state_e      r_state;
  logic [XLEN-1:0] r_dec_inst;
  logic [XLEN-1:0] r_dec_pc;

  logic w_valid;
  logic w_rd_rs1;
  logic w_rd_rs2;
  logic w_wr_rd;
  logic w_busy_rs1;
  logic w_busy_rs2;
  logic w_sat_rd;
  logic w_hazard;
  logic w_ex_valid;
  logic w_issue;
  logic w_if_ready;
  logic w_accept;

  assign w_valid  = (r_state != ST_EMPTY);
  assign w_rd_rs1 = op_reads_rs1(bus.id_opcode);
  assign w_rd_rs2 = op_reads_rs2(bus.id_opcode);
  assign w_wr_rd  = op_writes_rd(bus.id_opcode);

  // busy/sat already exclude x0 and include the same-cycle release.
  assign w_hazard   = (w_rd_rs1 && w_busy_rs1) ||
                      (w_rd_rs2 && w_busy_rs2) ||
                      (w_wr_rd  && w_sat_rd);
  assign w_ex_valid = w_valid && !w_hazard && !bus.flush;
  assign w_issue    = w_ex_valid && bus.ex_ready;
  assign w_if_ready = !w_valid || w_issue || bus.flush;
  assign w_accept   = bus.if_valid && w_if_ready;

  reg_scoreboard #(
    .PEND_W (PEND_W)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_iss_en   (w_issue && w_wr_rd),
    .i_iss_rd   (bus.id_rd),
    .i_rel_en   (bus.wb_valid),
    .i_rel_rd   (bus.wb_rd),
    .i_rs1      (bus.id_rs1),
    .i_rs2      (bus.id_rs2),
    .i_rd       (bus.id_rd),
    .o_busy_rs1 (w_busy_rs1),
    .o_busy_rs2 (w_busy_rs2),
    .o_sat_rd   (w_sat_rd),
    .o_sb_err   (bus.sb_err)
  );

  // FULL/HAZ record the scoreboard verdict of the last held cycle; the
  // issue decision itself always uses the live hazard term. A freshly
  // loaded instruction starts in FULL and is classified the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_dec_inst <= XLEN'(C_NOP);
      r_dec_pc   <= '0;
    end else begin
      if (w_accept) begin
        r_state    <= ST_FULL;
        r_dec_inst <= bus.if_inst;
        r_dec_pc   <= bus.if_pc;
      end else if (bus.flush || w_issue) begin
        r_state <= ST_EMPTY;
      end else if (w_valid) begin
        r_state <= w_hazard ? ST_HAZ : ST_FULL;
      end
    end
  end

  assign bus.dec_inst = r_dec_inst;
  assign bus.dec_pc   = r_dec_pc;
  assign bus.ex_valid = w_ex_valid;
  assign bus.if_ready = w_if_ready;

`ifdef DECODE_PERF_CNT_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_cnt;
  logic        w_stalled;

  // A cycle counts as stalled when the held instruction is blocked by the
  // scoreboard (and not being discarded).
  assign w_stalled = w_valid && w_hazard && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (w_stalled && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (bus.flush && w_valid && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_cnt    = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_issue_ctrl
//  Description : Self-checking bench for decode_issue_ctrl. A behavioural
//                reference (counter array + single instruction slot) is
//                compared against the DUT every falling edge; directed
//                scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue_ctrl;

  localparam int MAXC = 3;   // 2**PEND_W - 1 with PEND_W = 2

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_issue_ctrl_if #(.XLEN(32)) bus ();

  // Decoder stand-in: standard RV32 field positions.
  assign bus.id_opcode = bus.dec_inst[6:0];
  assign bus.id_rd     = bus.dec_inst[11:7];
  assign bus.id_rs1    = bus.dec_inst[19:15];
  assign bus.id_rs2    = bus.dec_inst[24:20];

`ifdef DECODE_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_cnt;
`endif

  decode_issue_ctrl #(.PEND_W(2), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DECODE_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_cnt    (flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  int          m_cnt[32];
  bit          m_err;

  function automatic bit reads1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit reads2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit writes(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111};
  endfunction

  function automatic int after_release(input int r);
    int c;
    c = m_cnt[r];
    if (bus.wb_valid && (int'(bus.wb_rd) == r) && r != 0 && c > 0) c = c - 1;
    return c;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 0;
      m_inst  = 32'h0000_0013;
      m_pc    = 32'h0;
      m_err   = 0;
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      chk("m_rst_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
      chk("m_rst_if_ready", {31'b0, bus.if_ready}, 32'd1);
      chk("m_rst_dec_inst", bus.dec_inst, 32'h0000_0013);
      chk("m_rst_sb_err", {31'b0, bus.sb_err}, 32'd0);
    end else begin
      automatic int  rs1 = int'(m_inst[19:15]);
      automatic int  rs2 = int'(m_inst[24:20]);
      automatic int  rd  = int'(m_inst[11:7]);
      automatic bit  haz, exv, iss, ifr, acc;
      automatic int  inc_r, dec_r;
      haz = (reads1(m_inst[6:0]) && rs1 != 0 && after_release(rs1) != 0) ||
            (reads2(m_inst[6:0]) && rs2 != 0 && after_release(rs2) != 0) ||
            (writes(m_inst[6:0]) && rd  != 0 && after_release(rd) == MAXC);
      exv = m_valid && !haz && !bus.flush;
      iss = exv && bus.ex_ready;
      ifr = !m_valid || iss || bus.flush;
      acc = bus.if_valid && ifr;

      chk("m_ex_valid", {31'b0, bus.ex_valid}, {31'b0, exv});
      chk("m_if_ready", {31'b0, bus.if_ready}, {31'b0, ifr});
      chk("m_sb_err", {31'b0, bus.sb_err}, {31'b0, m_err});
      if (m_valid) begin
        chk("m_dec_inst", bus.dec_inst, m_inst);
        chk("m_dec_pc", bus.dec_pc, m_pc);
      end

      inc_r = (iss && writes(m_inst[6:0]) && rd != 0) ? rd : 0;
      dec_r = (bus.wb_valid && bus.wb_rd != 0) ? int'(bus.wb_rd) : 0;
      if (!(inc_r != 0 && inc_r == dec_r)) begin
        if (inc_r != 0) m_cnt[inc_r] = m_cnt[inc_r] + 1;
        if (dec_r != 0) begin
          if (m_cnt[dec_r] == 0) m_err = 1;
          else m_cnt[dec_r] = m_cnt[dec_r] - 1;
        end
      end

      if (acc) begin
        m_valid = 1;
        m_inst  = bus.if_inst;
        m_pc    = bus.if_pc;
      end else if (iss || bus.flush) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer an instruction until accepted; returns 1 time unit after the
  // accepting edge with if_valid dropped.
  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    int n;
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    n = 0;
    #1;
    while (!bus.if_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 50) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.if_valid = 1'b0;
  endtask

  task automatic rel(input logic [4:0] r);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = r;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  localparam logic [31:0] ADDI5  = 32'h0010_0293; // addi x5,x0,1
  localparam logic [31:0] ADD6   = 32'h0052_8333; // add x6,x5,x5
  localparam logic [31:0] ADDI7  = 32'h0010_0393; // addi x7,x0,1
  localparam logic [31:0] ADDI10 = 32'h0010_0513; // addi x10,x0,1
  localparam logic [31:0] ADDI12 = 32'h0010_0613; // addi x12,x0,1
  localparam logic [31:0] LUI8   = 32'h1234_5437; // lui x8,0x12345
  localparam logic [31:0] NOP    = 32'h0000_0013;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_valid = 0; bus.if_inst = 0; bus.if_pc = 0;
    bus.ex_ready = 1; bus.wb_valid = 0; bus.wb_rd = 0; bus.flush = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dec_inst", bus.dec_inst, NOP);
    chk("rst_dec_pc", bus.dec_pc, 32'h0);
    chk("rst_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("rst_if_ready", {31'b0, bus.if_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // RAW hazard with same-cycle release bypass
    push(ADDI5, 32'h100);
    #1 chk("addi_ex_valid", {31'b0, bus.ex_valid}, 32'd1);
    push(ADD6, 32'h104);
    #1 chk("raw_stall", {31'b0, bus.ex_valid}, 32'd0);
    chk("raw_if_ready", {31'b0, bus.if_ready}, 32'd0);
    tick();
    #1 chk("raw_stall2", {31'b0, bus.ex_valid}, 32'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
    #1 chk("raw_bypass", {31'b0, bus.ex_valid}, 32'd1);
    tick();
    bus.wb_valid = 1'b0;
    #1 chk("raw_empty", {31'b0, bus.ex_valid}, 32'd0);
    rel(5'd6);

    // Scoreboard saturation on x7
    push(ADDI7, 32'h110);
    push(ADDI7, 32'h114);
    push(ADDI7, 32'h118);
    push(ADDI7, 32'h11c);
    #1 chk("sat_stall", {31'b0, bus.ex_valid}, 32'd0);
    tick();
    #1 chk("sat_stall2", {31'b0, bus.ex_valid}, 32'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7;
    #1 chk("sat_release", {31'b0, bus.ex_valid}, 32'd1);
    tick();
    bus.wb_valid = 1'b0;
    rel(5'd7); rel(5'd7); rel(5'd7);

    // Hold under back-pressure, then issue + accept in one cycle
    bus.ex_ready = 1'b0;
    push(LUI8, 32'h200);
    bus.if_valid = 1'b1; bus.if_inst = NOP; bus.if_pc = 32'h204;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_inst", bus.dec_inst, LUI8);
      chk("hold_pc", bus.dec_pc, 32'h200);
      chk("hold_if_ready", {31'b0, bus.if_ready}, 32'd0);
      @(posedge clk);
    end
    #1 bus.ex_ready = 1'b1;
    #1 chk("hold_release_ifr", {31'b0, bus.if_ready}, 32'd1);
    @(posedge clk);
    #1 bus.if_valid = 1'b0;
    #1 chk("next_inst", bus.dec_inst, NOP);
    chk("next_pc", bus.dec_pc, 32'h204);
    tick();
    rel(5'd8);

    // Flush while blocked, loading a NOP in the same cycle
    push(ADDI10, 32'h300);
    push(rtype(5'd11, 5'd10, 5'd10), 32'h304);
    #1 chk("flush_haz", {31'b0, bus.ex_valid}, 32'd0);
    tick();
    bus.flush = 1'b1; bus.if_valid = 1'b1; bus.if_inst = NOP; bus.if_pc = 32'h308;
    #1 chk("flush_no_issue", {31'b0, bus.ex_valid}, 32'd0);
    chk("flush_if_ready", {31'b0, bus.if_ready}, 32'd1);
    @(posedge clk);
    #1 bus.flush = 1'b0; bus.if_valid = 1'b0;
    #1 chk("flush_nop_loaded", bus.dec_inst, NOP);
    chk("flush_nop_issue", {31'b0, bus.ex_valid}, 32'd1);
    tick();
    push(rtype(5'd11, 5'd10, 5'd10), 32'h30c);
    #1 chk("flush_cnt_kept", {31'b0, bus.ex_valid}, 32'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    rel(5'd10);

    // sb_err: x0 release ignored, zero-count release sets sticky error
    rel(5'd0);
    #1 chk("err_x0", {31'b0, bus.sb_err}, 32'd0);
    rel(5'd9);
    #1 chk("err_set", {31'b0, bus.sb_err}, 32'd1);
    tick(); tick();
    #1 chk("err_sticky", {31'b0, bus.sb_err}, 32'd1);

    // Asynchronous reset mid-stream with x12 outstanding
    push(ADDI12, 32'h400);
    tick();
    bus.ex_ready = 1'b0;
    push(LUI8, 32'h404);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dec_inst", bus.dec_inst, NOP);
    chk("arst_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("arst_if_ready", {31'b0, bus.if_ready}, 32'd1);
    chk("arst_sb_err", {31'b0, bus.sb_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; bus.ex_ready = 1'b1;
    push(rtype(5'd13, 5'd12, 5'd12), 32'h500);
    #1 chk("arst_cnt_clear", {31'b0, bus.ex_valid}, 32'd1);
    tick();
    rel(5'd13);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
